// File: rtl/ecc_result_monitor.sv
// Run-time monitor for the ECC encoder/decoder APB slave.
// Tracks control-register writes, enforces the operation_done latency window,
// compares DUT results against queued golden results and checks APB reads.
// All violations land in saturating counters plus a sticky error flag.
module ecc_result_monitor #(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int MAX_LATENCY     = 5,
  parameter int FIFO_DEPTH      = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  input  logic [AMBA_WORD-1:0]       RegistersOut,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic                       operation_done,
  input  logic [1:0]                 num_of_errors,
  input  logic                       gm_valid,
  input  logic [DATA_WIDTH-1:0]      gm_DATA_OUT,
  input  logic [1:0]                 gm_number_of_errors,
  output logic [CNT_WIDTH-1:0]       ops_checked,
  output logic [CNT_WIDTH-1:0]       mismatch_cnt,
  output logic [CNT_WIDTH-1:0]       timeout_cnt,
  output logic [CNT_WIDTH-1:0]       unexp_done_cnt,
  output logic [CNT_WIDTH-1:0]       overlap_cnt,
  output logic [CNT_WIDTH-1:0]       read_err_cnt,
  output logic                       fifo_overflow,
  output logic                       err_flag,
  output logic                       busy
);

  // lat only ever holds 0 .. MAX_LATENCY-1 while waiting
  localparam int LAT_W = (MAX_LATENCY > 1) ? $clog2(MAX_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MAX_LATENCY - 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                  state;
  logic [LAT_W-1:0]        lat;
  logic [DATA_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
  logic [1:0]              fifo_errs [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W:0]          count;

  logic start, rd, fifo_empty, fifo_full;
  logic do_compare, bypass, pop, push, push_req;
  logic overflow_ev, mismatch_ev, timeout_ev, overlap_ev, unexp_ev, read_ev;
  logic any_err_ev;
  logic [DATA_WIDTH-1:0] ref_data;
  logic [1:0]            ref_errs;
  logic                  unused_addr;

  assign unused_addr = ^PADDR[AMBA_ADDR_WIDTH-1:4];
  assign busy        = (state == WAIT);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  // Decode APB events and decide compare source, FIFO traffic and error events
  always_comb begin
    start       = PSEL & PENABLE & PWRITE & (PADDR[3:0] == 4'b0000);
    rd          = PSEL & PENABLE & ~PWRITE;
    fifo_empty  = (count == '0);
    fifo_full   = (count == FIFO_FULL_CNT);
    do_compare  = 1'b0;
    bypass      = 1'b0;
    unexp_ev    = 1'b0;
    if (operation_done) begin
      if (state == IDLE) begin
        unexp_ev = 1'b1;
      end else if (!fifo_empty) begin
        do_compare = 1'b1;
      end else if (gm_valid) begin
        do_compare = 1'b1;
        bypass     = 1'b1;
      end else begin
        unexp_ev = 1'b1;
      end
    end
    pop         = do_compare & ~bypass;
    push_req    = gm_valid & ~bypass;
    push        = push_req & (~fifo_full | pop);
    overflow_ev = push_req & fifo_full & ~pop;
    ref_data    = bypass ? gm_DATA_OUT : fifo_data[rd_ptr];
    ref_errs    = bypass ? gm_number_of_errors : fifo_errs[rd_ptr];
    mismatch_ev = do_compare & ((data_out != ref_data) | (num_of_errors != ref_errs));
    overlap_ev  = (state == WAIT) & start;
    timeout_ev  = (state == WAIT) & ~start & ~operation_done & (lat == LAT_LAST);
    read_ev     = rd & (PRDATA != RegistersOut);
    any_err_ev  = mismatch_ev | timeout_ev | unexp_ev | overlap_ev | read_ev;
  end

  // Golden-result storage; occupancy and pointers live with the control state
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      fifo_data[wr_ptr] <= gm_DATA_OUT;
      fifo_errs[wr_ptr] <= gm_number_of_errors;
    end
  end

  // Latency FSM, FIFO pointers, saturating counters and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      lat            <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      ops_checked    <= '0;
      mismatch_cnt   <= '0;
      timeout_cnt    <= '0;
      unexp_done_cnt <= '0;
      overlap_cnt    <= '0;
      read_err_cnt   <= '0;
      fifo_overflow  <= 1'b0;
      err_flag       <= 1'b0;
    end else if (clr) begin
      state          <= IDLE;
      lat            <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      ops_checked    <= '0;
      mismatch_cnt   <= '0;
      timeout_cnt    <= '0;
      unexp_done_cnt <= '0;
      overlap_cnt    <= '0;
      read_err_cnt   <= '0;
      fifo_overflow  <= 1'b0;
      err_flag       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= WAIT;
            lat   <= '0;
          end
        end
        WAIT: begin
          if (start) begin
            lat <= '0;
          end else if (operation_done || (lat == LAT_LAST)) begin
            state <= IDLE;
            lat   <= '0;
          end else begin
            lat <= lat + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          lat   <= '0;
        end
      endcase

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      ops_checked    <= sat_inc(ops_checked, do_compare);
      mismatch_cnt   <= sat_inc(mismatch_cnt, mismatch_ev);
      timeout_cnt    <= sat_inc(timeout_cnt, timeout_ev);
      unexp_done_cnt <= sat_inc(unexp_done_cnt, unexp_ev);
      overlap_cnt    <= sat_inc(overlap_cnt, overlap_ev);
      read_err_cnt   <= sat_inc(read_err_cnt, read_ev);
      fifo_overflow  <= fifo_overflow | overflow_ev;
      err_flag       <= err_flag | any_err_ev;
    end
  end

endmodule

// File: tb/tb_ecc_result_monitor.sv
// Self-checking bench for ecc_result_monitor: two instances (16-bit and 2-bit
// counters) share one stimulus stream and are compared every cycle against a
// queue-based behavioural model; literal expectations pin key scenarios.
module tb_ecc_result_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [19:0] paddr = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] prdata = '0, registers_out = '0;
  logic [31:0] data_out = '0;
  logic        operation_done = 1'b0;
  logic [1:0]  num_of_errors = '0;
  logic        gm_valid = 1'b0;
  logic [31:0] gm_data = '0;
  logic [1:0]  gm_errs = '0;

  logic [15:0] ops_l, mism_l, tmo_l, unexp_l, ovl_l, rderr_l;
  logic        ovf_l, errf_l, busy_l;
  logic [1:0]  ops_s, mism_s, tmo_s, unexp_s, ovl_s, rderr_s;
  logic        ovf_s, errf_s, busy_s;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state: raw event counts, golden queue, wait age
  int          m_ops, m_mism, m_tmo, m_unexp, m_ovl, m_rderr;
  bit          m_ovf, m_errf, m_waiting;
  int          m_age;
  logic [33:0] m_q[$];

  always #5 clk = ~clk;

  ecc_result_monitor #(.CNT_WIDTH(16)) dut_main (
    .clk(clk), .rst(rst), .clr(clr), .PADDR(paddr), .PSEL(psel), .PENABLE(penable),
    .PWRITE(pwrite), .PRDATA(prdata), .RegistersOut(registers_out), .data_out(data_out),
    .operation_done(operation_done), .num_of_errors(num_of_errors), .gm_valid(gm_valid),
    .gm_DATA_OUT(gm_data), .gm_number_of_errors(gm_errs), .ops_checked(ops_l),
    .mismatch_cnt(mism_l), .timeout_cnt(tmo_l), .unexp_done_cnt(unexp_l),
    .overlap_cnt(ovl_l), .read_err_cnt(rderr_l), .fifo_overflow(ovf_l),
    .err_flag(errf_l), .busy(busy_l));

  ecc_result_monitor #(.CNT_WIDTH(2)) dut_small (
    .clk(clk), .rst(rst), .clr(clr), .PADDR(paddr), .PSEL(psel), .PENABLE(penable),
    .PWRITE(pwrite), .PRDATA(prdata), .RegistersOut(registers_out), .data_out(data_out),
    .operation_done(operation_done), .num_of_errors(num_of_errors), .gm_valid(gm_valid),
    .gm_DATA_OUT(gm_data), .gm_number_of_errors(gm_errs), .ops_checked(ops_s),
    .mismatch_cnt(mism_s), .timeout_cnt(tmo_s), .unexp_done_cnt(unexp_s),
    .overlap_cnt(ovl_s), .read_err_cnt(rderr_s), .fifo_overflow(ovf_s),
    .err_flag(errf_s), .busy(busy_s));

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic modelReset();
    m_ops = 0; m_mism = 0; m_tmo = 0; m_unexp = 0; m_ovl = 0; m_rderr = 0;
    m_ovf = 0; m_errf = 0; m_waiting = 0; m_age = 0;
    m_q.delete();
  endtask

  // Model: evaluate each clock edge from the rules of operation
  always @(posedge clk or posedge rst) begin
    bit          st, was_waiting, consumed;
    logic [33:0] g;
    if (rst || clr) begin
      modelReset();
    end else begin
      st          = psel & penable & pwrite & (paddr[3:0] == 4'd0);
      was_waiting = m_waiting;
      consumed    = 0;
      if (psel && penable && !pwrite && prdata != registers_out) begin
        m_rderr++; m_errf = 1;
      end
      if (operation_done) begin
        if (!was_waiting) begin
          m_unexp++; m_errf = 1;
        end else if (m_q.size() > 0 || gm_valid) begin
          if (m_q.size() > 0) g = m_q.pop_front();
          else begin
            g = {gm_errs, gm_data};
            consumed = 1;
          end
          m_ops++;
          if (g != {num_of_errors, data_out}) begin
            m_mism++; m_errf = 1;
          end
        end else begin
          m_unexp++; m_errf = 1;
        end
      end
      if (gm_valid && !consumed) begin
        if (m_q.size() < 4) m_q.push_back({gm_errs, gm_data});
        else m_ovf = 1;
      end
      if (was_waiting) begin
        if (st) begin
          m_ovl++; m_errf = 1; m_age = 0;
        end else if (operation_done) begin
          m_waiting = 0;
        end else begin
          m_age++;
          if (m_age == 5) begin
            m_tmo++; m_errf = 1; m_waiting = 0;
          end
        end
      end else if (st) begin
        m_waiting = 1; m_age = 0;
      end
    end
  end

  // Compare both instances against the model every falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("ops_l",   ops_l,   sat(m_ops, 65535));
      checkOutput("mism_l",  mism_l,  sat(m_mism, 65535));
      checkOutput("tmo_l",   tmo_l,   sat(m_tmo, 65535));
      checkOutput("unexp_l", unexp_l, sat(m_unexp, 65535));
      checkOutput("ovl_l",   ovl_l,   sat(m_ovl, 65535));
      checkOutput("rderr_l", rderr_l, sat(m_rderr, 65535));
      checkOutput("ovf_l",   ovf_l,   m_ovf);
      checkOutput("errf_l",  errf_l,  m_errf);
      checkOutput("busy_l",  busy_l,  m_waiting);
      checkOutput("ops_s",   ops_s,   sat(m_ops, 3));
      checkOutput("mism_s",  mism_s,  sat(m_mism, 3));
      checkOutput("tmo_s",   tmo_s,   sat(m_tmo, 3));
      checkOutput("unexp_s", unexp_s, sat(m_unexp, 3));
      checkOutput("ovl_s",   ovl_s,   sat(m_ovl, 3));
      checkOutput("rderr_s", rderr_s, sat(m_rderr, 3));
      checkOutput("ovf_s",   ovf_s,   m_ovf);
      checkOutput("errf_s",  errf_s,  m_errf);
      checkOutput("busy_s",  busy_s,  m_waiting);
    end
  end

  // Drive one cycle of inputs just after the falling edge
  task automatic applyStimulus(input bit st, input bit rdv, input bit dn,
                               input logic [31:0] dout, input logic [1:0] nerr,
                               input bit gv, input logic [31:0] gd, input logic [1:0] ge,
                               input logic [31:0] prd, input logic [31:0] regv, input bit c);
    @(negedge clk);
    psel           = st | rdv;
    penable        = st | rdv;
    pwrite         = st;
    paddr          = rdv ? 20'h4 : 20'h0;
    prdata         = prd;
    registers_out  = regv;
    operation_done = dn;
    data_out       = dout;
    num_of_errors  = nerr;
    gm_valid       = gv;
    gm_data        = gd;
    gm_errs        = ge;
    clr            = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic doStart();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic doGolden(input logic [31:0] d, input logic [1:0] e);
    applyStimulus(0, 0, 0, 0, 0, 1, d, e, 0, 0, 0);
  endtask
  task automatic doDone(input logic [31:0] d, input logic [1:0] e);
    applyStimulus(0, 0, 1, d, e, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic doDoneGolden(input logic [31:0] d, input logic [1:0] e,
                              input logic [31:0] gd, input logic [1:0] ge);
    applyStimulus(0, 0, 1, d, e, 1, gd, ge, 0, 0, 0);
  endtask
  task automatic doRead(input logic [31:0] p, input logic [31:0] r);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, p, r, 0);
  endtask
  task automatic doClr();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Literal expectation pinning both the DUT and the model
  task automatic expectLit(input string name, input logic [31:0] dut_val,
                           input int model_val, input logic [31:0] lit);
    checkOutput({name, "_dut"}, dut_val, lit);
    checkOutput({name, "_model"}, model_val, lit);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    idle(1);
    expectLit("reset_ops", ops_l, m_ops, 0);
    expectLit("reset_busy", busy_l, int'(m_waiting), 0);
    expectLit("reset_errf", errf_l, int'(m_errf), 0);

    // Matching compare through the FIFO
    doStart();
    doGolden(32'hA5A5A5A5, 2'd1);
    doDone(32'hA5A5A5A5, 2'd1);
    idle(1);
    expectLit("t1_ops", ops_l, m_ops, 1);
    expectLit("t1_mism", mism_l, m_mism, 0);
    expectLit("t1_errf", errf_l, int'(m_errf), 0);

    // Mismatching compare via same-cycle bypass at N+3
    doStart();
    idle(2);
    doDoneGolden(32'hA5A5A5A4, 2'd1, 32'hA5A5A5A5, 2'd1);
    idle(1);
    expectLit("t2_mism", mism_l, m_mism, 1);
    expectLit("t2_errf", errf_l, int'(m_errf), 1);

    // Timeout after edge N+5, then late done is unexpected
    doStart();
    idle(4);
    checkOutput("t3_no_tmo_yet", tmo_l, 0);
    idle(1);
    doDone(32'h1, 2'd0);
    expectLit("t3_tmo", tmo_l, m_tmo, 1);
    idle(1);
    expectLit("t3_unexp", unexp_l, m_unexp, 1);
    checkOutput("t3_busy", busy_l, 0);

    // FIFO fill, push+pop while full, overflow, drain
    doClr();
    for (int i = 0; i < 4; i++) doGolden(32'h100 + i, 2'(i));
    doStart();
    doDoneGolden(32'h100, 2'd0, 32'h104, 2'd0);
    idle(1);
    expectLit("t4_no_ovf", ovf_l, int'(m_ovf), 0);
    doGolden(32'h105, 2'd1);
    idle(1);
    expectLit("t4_ovf", ovf_l, int'(m_ovf), 1);
    for (int i = 1; i < 5; i++) begin
      doStart();
      doDone(32'h100 + i, (i == 4) ? 2'd0 : 2'(i));
    end
    idle(1);
    expectLit("t4_ops", ops_l, m_ops, 5);
    expectLit("t4_mism", mism_l, m_mism, 0);
    doStart();
    doDone(32'h105, 2'd1);
    idle(1);
    expectLit("t4_empty_unexp", unexp_l, m_unexp, 1);

    // Read error, then clear
    doRead(32'h3, 32'h2);
    idle(1);
    expectLit("t5_rderr", rderr_l, m_rderr, 1);
    doClr();
    idle(1);
    expectLit("t5_clr_rderr", rderr_l, m_rderr, 0);
    expectLit("t5_clr_errf", errf_l, int'(m_errf), 0);
    expectLit("t5_clr_ovf", ovf_l, int'(m_ovf), 0);

    // Saturation on the 2-bit instance
    for (int i = 0; i < 4; i++) doRead(32'hF0 + i, 32'h0);
    idle(1);
    checkOutput("t6_rderr_sat", rderr_s, 3);
    checkOutput("t6_rderr_wide", rderr_l, 4);

    // Overlap with simultaneous done, then done at the last legal edge
    doStart();
    doStart();
    doDoneGolden(32'h55, 2'd2, 32'h55, 2'd2);
    idle(1);
    expectLit("t7_ovl", ovl_l, m_ovl, 1);
    doStart();
    idle(4);
    doDoneGolden(32'h77, 2'd0, 32'h77, 2'd0);
    idle(1);
    expectLit("t7_edge_tmo", tmo_l, m_tmo, 0);
    expectLit("t7_edge_ops", ops_l, m_ops, 2);

    // Asynchronous reset mid-WAIT
    doStart();
    idle(1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t8_rst_busy", busy_l, 0);
    checkOutput("t8_rst_rderr", rderr_l, 0);
    checkOutput("t8_rst_ops", ops_l, 0);
    checkOutput("t8_rst_errf", errf_s, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(8);
    checkOutput("t8_no_tmo", tmo_l, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_result_monitor.md
# ecc_result_monitor

Parametrised, synthesizable run-time monitor for the ECC encoder/decoder APB slave. It tracks every control-register write ("start"), enforces an operation_done latency window, and queues golden-model results in a FIFO. It compares each DUT result against the queued golden result and checks APB read data. Violations are accumulated in saturating counters and a sticky flag, so the same block serves simulation benches and FPGA bring-up.

## Interface
- DATA_WIDTH, 32, width of data_out / gm_DATA_OUT
- AMBA_ADDR_WIDTH, 20, PADDR width
- AMBA_WORD, 32, PRDATA / RegistersOut width
- MAX_LATENCY, 5, last legal cycle for operation_done after start (≥1)
- FIFO_DEPTH, 4, golden-result queue depth (power of two, ≥2)
- CNT_WIDTH, 16, width of every event counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of counters, sticky flag and FIFO
- PADDR  in  AMBA_ADDR_WIDTH  APB address
- PSEL, PENABLE, PWRITE  in  1 each  APB control
- PRDATA  in  AMBA_WORD  DUT read data
- RegistersOut  in  AMBA_WORD  expected register read value
- data_out  in  DATA_WIDTH  DUT result
- operation_done  in  1  DUT result strobe
- num_of_errors  in  2  DUT error count
- gm_valid  in  1  golden result strobe
- gm_DATA_OUT  in  DATA_WIDTH  golden data
- gm_number_of_errors  in  2  golden error count
- ops_checked  out  CNT_WIDTH  results compared
- mismatch_cnt  out  CNT_WIDTH  data or error-count mismatches
- timeout_cnt  out  CNT_WIDTH  missing operation_done
- unexp_done_cnt  out  CNT_WIDTH  done outside a window, or no golden result available
- overlap_cnt  out  CNT_WIDTH  start while already waiting
- read_err_cnt  out  CNT_WIDTH  PRDATA ≠ RegistersOut
- fifo_overflow  out  1  sticky, golden push dropped
- err_flag  out  1  sticky, any error counter incremented
- busy  out  1  state == WAIT

## Operation
- start = PSEL & PENABLE & PWRITE & (PADDR[3:0]==4'b0000).
- rd = PSEL & PENABLE & ~PWRITE.
- FSM states: IDLE, WAIT.
  - IDLE → WAIT on start; latency counter lat loads 0.
  - WAIT: lat increments each cycle.
  - WAIT, operation_done with 1 ≤ lat+1 ≤ MAX_LATENCY: perform compare, → IDLE.
  - WAIT, lat+1 == MAX_LATENCY and no done: timeout_cnt++, → IDLE.
  - WAIT, start (with or without done): overlap_cnt++, lat reloads 0, stay WAIT. A simultaneous done is still compared.
- operation_done in IDLE, including the start cycle: unexp_done_cnt++, no compare, no FIFO pop.
- Golden FIFO:
  - push on gm_valid; pop on each compare.
  - Compare when FIFO empty and gm_valid in the same cycle: bypass and compare directly, no push.
  - Compare when FIFO empty, no gm_valid: unexp_done_cnt++, no compare.
  - Push when full without a simultaneous pop: data dropped, fifo_overflow set.
  - Push and pop together when full: legal.
- Compare: ops_checked++; if data_out ≠ gm_DATA_OUT or num_of_errors ≠ gm_number_of_errors, mismatch_cnt++.
- Read check: on rd, if PRDATA ≠ RegistersOut, read_err_cnt++.
- All counters saturate at 2^CNT_WIDTH−1 and never wrap.
- err_flag sets on any increment of mismatch, timeout, unexp_done, overlap or read_err; cleared only by rst or clr.
- clr: counters 0, FIFO emptied, flags 0, FSM → IDLE. Events in the clr cycle are discarded.

## Timing
- Reset (async assert, sync release): IDLE, lat 0, FIFO empty, all counters 0, fifo_overflow 0, err_flag 0, busy 0.
- Reset mid-WAIT aborts the operation; no timeout is recorded.
- Start sampled at edge N; operation_done is legal at edges N+1 … N+MAX_LATENCY.
- If done is absent through edge N+MAX_LATENCY, timeout_cnt reflects it after edge N+MAX_LATENCY.
- All outputs are registered: every counter and flag updates one cycle after the causing event.
- busy rises the cycle after start and falls the cycle after compare or timeout.
- FIFO has 1-cycle write-to-read latency. The bypass covers same-cycle push and empty-compare.

## Test plan
- Start, gm_valid at N+1 (data 0xA5A5A5A5, errs 1), matching done at N+2 → ops_checked=1, mismatch_cnt=0, err_flag=0.
- Start, done at N+3 with data_out 0xA5A5A5A4 → mismatch_cnt=1, err_flag=1.
- MAX_LATENCY=5: start, no done for 6 cycles → timeout_cnt=1 after edge N+5; a done at N+6 → unexp_done_cnt=1.
- 5 gm_valid pushes with no compares (FIFO_DEPTH=4) → fifo_overflow=1. Four subsequent starts with matching dones → ops_checked=4, FIFO empty.
- APB read with PRDATA=0x3, RegistersOut=0x2 → read_err_cnt=1. Then clr → all counters 0, err_flag 0.
- CNT_WIDTH=2: four reads with mismatching PRDATA → read_err_cnt stays 3. rst asserted mid-WAIT → all outputs 0 asynchronously.
